// File: rtl/data_bus_arbiter.sv
// Two-master arbiter in front of a single synchronous-read RAM port.
// Fixed latency: request sampled at edge N -> RAM access in cycle N+1 -> ack in cycle N+2.
module data_bus_arbiter #(
  parameter int unsigned WORD_CNT   = 1024,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0Req,
  input  logic        m0Wr,
  input  logic [31:0] m0Addr,
  input  logic [31:0] m0WrData,
  input  logic [3:0]  m0WrMask,
  output logic        m0Ack,
  output logic        m0Err,
  output logic [31:0] m0RdData,

  input  logic        m1Req,
  input  logic        m1Wr,
  input  logic [31:0] m1Addr,
  input  logic [31:0] m1WrData,
  input  logic [3:0]  m1WrMask,
  output logic        m1Ack,
  output logic        m1Err,
  output logic [31:0] m1RdData,

  output logic [31:0] memAddr,
  output logic [31:0] memWriteData,
  output logic [3:0]  memWrMask,
  output logic        memWr,
  input  logic [31:0] memReadData
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam logic [AW-1:0] WORD_LIMIT = AW'(WORD_CNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           owner_q, owner_d;     // 0 = M0, 1 = M1
  logic           prio_q, prio_d;       // master favoured on the next tie
  logic           wr_q, wr_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [MW-1:0]  mask_q, mask_d;
  logic           oor_q, oor_d;

  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic [MW-1:0]  mem_mask_q, mem_mask_d;
  logic           mem_wr_q, mem_wr_d;

  logic           ack0_q, ack0_d, ack1_q, ack1_d;
  logic           err0_q, err0_d, err1_q, err1_d;
  logic           rd0_q, rd0_d, rd1_q, rd1_d;  // owner's read data passes through in RESP

  logic           cand_m0, cand_m1, grant;

  // Next-state, arbitration and latch logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    oor_d       = oor_q;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_mask_d  = '0;
    mem_wr_d    = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    rd0_d       = 1'b0;
    rd1_d       = 1'b0;
    cand_m0     = 1'b0;
    cand_m1     = 1'b0;
    grant       = 1'b0;

    case (state_q)
      IDLE: begin
        cand_m0 = m0Req;
        cand_m1 = m1Req;
      end
      ISSUE: begin
        state_d = RESP;
        ack0_d  = ~owner_q;
        ack1_d  = owner_q;
        err0_d  = ~owner_q & oor_q;
        err1_d  = owner_q & oor_q;
        rd0_d   = ~owner_q & ~wr_q & ~oor_q;
        rd1_d   = owner_q & ~wr_q & ~oor_q;
      end
      RESP: begin
        // Owner's req is still high here; only the other master may be granted.
        state_d = IDLE;
        cand_m0 = m0Req & owner_q;
        cand_m1 = m1Req & ~owner_q;
      end
      default: state_d = IDLE;
    endcase

    if (cand_m0 || cand_m1) begin
      if (cand_m0 && cand_m1) begin
        grant = FIXED_PRIO ? 1'b0 : prio_q;
      end else begin
        grant = cand_m1;
      end
      state_d     = ISSUE;
      owner_d     = grant;
      prio_d      = ~grant;
      wr_d        = grant ? m1Wr     : m0Wr;
      addr_d      = grant ? m1Addr   : m0Addr;
      wdata_d     = grant ? m1WrData : m0WrData;
      mask_d      = grant ? m1WrMask : m0WrMask;
      oor_d       = ({2'b00, addr_d[AW-1:2]} >= WORD_LIMIT);
      mem_addr_d  = addr_d;
      mem_wdata_d = wdata_d;
      mem_mask_d  = mask_d;
      mem_wr_d    = wr_d & ~oor_d;
    end
  end

  // State, latched transfer and registered outputs; reset drops any transfer in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      prio_q      <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      oor_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      mem_wr_q    <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rd0_q       <= 1'b0;
      rd1_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      oor_q       <= oor_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
      mem_wr_q    <= mem_wr_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rd0_q       <= rd0_d;
      rd1_q       <= rd1_d;
    end
  end

  assign memAddr      = mem_addr_q;
  assign memWriteData = mem_wdata_q;
  assign memWrMask    = mem_mask_q;
  assign memWr        = mem_wr_q;

  assign m0Ack    = ack0_q;
  assign m1Ack    = ack1_q;
  assign m0Err    = err0_q;
  assign m1Err    = err1_q;
  // RAM read data arrives in the RESP cycle, so it is gated rather than registered
  assign m0RdData = rd0_q ? memReadData : '0;
  assign m1RdData = rd1_q ? memReadData : '0;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench: round-robin instance with a RAM model, plus a fixed-priority instance on the same inputs.
module tb_data_bus_arbiter;

  localparam int unsigned WORDS = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0Req, m0Wr, m1Req, m1Wr;
  logic [31:0] m0Addr, m0WrData, m1Addr, m1WrData;
  logic [3:0]  m0WrMask, m1WrMask;

  logic        m0Ack, m0Err, m1Ack, m1Err, memWr;
  logic [31:0] m0RdData, m1RdData, memAddr, memWriteData;
  logic [3:0]  memWrMask;

  logic        fp_m0Ack, fp_m0Err, fp_m1Ack, fp_m1Err, fp_memWr;
  logic [31:0] fp_m0RdData, fp_m1RdData, fp_memAddr, fp_memWriteData;
  logic [3:0]  fp_memWrMask;

  logic        mem_init;
  logic [31:0] mem [WORDS];
  logic [31:0] mem_rdata;

  int n_vec;
  int n_err;

  always #5 clk = ~clk;

  data_bus_arbiter #(.WORD_CNT(WORDS), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .m0Req(m0Req), .m0Wr(m0Wr), .m0Addr(m0Addr), .m0WrData(m0WrData), .m0WrMask(m0WrMask),
    .m0Ack(m0Ack), .m0Err(m0Err), .m0RdData(m0RdData),
    .m1Req(m1Req), .m1Wr(m1Wr), .m1Addr(m1Addr), .m1WrData(m1WrData), .m1WrMask(m1WrMask),
    .m1Ack(m1Ack), .m1Err(m1Err), .m1RdData(m1RdData),
    .memAddr(memAddr), .memWriteData(memWriteData), .memWrMask(memWrMask), .memWr(memWr),
    .memReadData(mem_rdata)
  );

  data_bus_arbiter #(.WORD_CNT(WORDS), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0Req(m0Req), .m0Wr(m0Wr), .m0Addr(m0Addr), .m0WrData(m0WrData), .m0WrMask(m0WrMask),
    .m0Ack(fp_m0Ack), .m0Err(fp_m0Err), .m0RdData(fp_m0RdData),
    .m1Req(m1Req), .m1Wr(m1Wr), .m1Addr(m1Addr), .m1WrData(m1WrData), .m1WrMask(m1WrMask),
    .m1Ack(fp_m1Ack), .m1Err(fp_m1Err), .m1RdData(fp_m1RdData),
    .memAddr(fp_memAddr), .memWriteData(fp_memWriteData), .memWrMask(fp_memWrMask), .memWr(fp_memWr),
    .memReadData(32'h0)
  );

  // RAM model: byte-masked write, one-cycle read latency; index wraps so a stray out-of-range write would alias
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < int'(WORDS); i++) mem[4'(i)] <= '0;
      mem_rdata <= '0;
    end else begin
      if (memWr) begin
        for (int b = 0; b < 4; b++) begin
          if (memWrMask[2'(b)]) mem[memAddr[5:2]][8*b +: 8] <= memWriteData[8*b +: 8];
        end
      end
      mem_rdata <= mem[memAddr[5:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated transfer: latch, ISSUE checks, ack checks, back to IDLE
  task automatic xfer(input string tag, input bit mst, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] mask,
                      input bit exp_wr, input bit exp_err, input logic [31:0] exp_rd);
    if (!mst) begin
      m0Req = 1'b1; m0Wr = wr; m0Addr = addr; m0WrData = data; m0WrMask = mask;
    end else begin
      m1Req = 1'b1; m1Wr = wr; m1Addr = addr; m1WrData = data; m1WrMask = mask;
    end
    step();
    check($sformatf("%s memWr", tag), 32'(memWr), 32'(exp_wr));
    check($sformatf("%s memAddr", tag), memAddr, addr);
    check($sformatf("%s memWriteData", tag), memWriteData, data);
    check($sformatf("%s memWrMask", tag), 32'(memWrMask), 32'(mask));
    check($sformatf("%s early ack", tag), 32'({m1Ack, m0Ack}), 32'd0);
    // Drop request and disturb inputs after the latch; the transfer must still complete unchanged
    m0Req = 1'b0; m1Req = 1'b0;
    m0Addr = ~addr; m1Addr = ~addr; m0WrData = ~data; m1WrData = ~data;
    step();
    check($sformatf("%s ack", tag), 32'(mst ? m1Ack : m0Ack), 32'd1);
    check($sformatf("%s other ack", tag), 32'(mst ? m0Ack : m1Ack), 32'd0);
    check($sformatf("%s err", tag), 32'(mst ? m1Err : m0Err), 32'(exp_err));
    check($sformatf("%s rdData", tag), mst ? m1RdData : m0RdData, exp_rd);
    check($sformatf("%s memWr in RESP", tag), 32'(memWr), 32'd0);
    step();
    check($sformatf("%s ack one cycle", tag), 32'({m1Ack, m0Ack}), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    mem_init = 1'b1;
    m0Req = 1'b0; m0Wr = 1'b0; m0Addr = '0; m0WrData = '0; m0WrMask = '0;
    m1Req = 1'b0; m1Wr = 1'b0; m1Addr = '0; m1WrData = '0; m1WrMask = '0;

    repeat (2) step();
    check("rst acks", 32'({m1Ack, m0Ack}), 32'd0);
    check("rst errs", 32'({m1Err, m0Err}), 32'd0);
    check("rst rd0", m0RdData, 32'd0);
    check("rst rd1", m1RdData, 32'd0);
    check("rst memWr", 32'(memWr), 32'd0);
    check("rst memAddr", memAddr, 32'd0);
    check("rst memWriteData", memWriteData, 32'd0);
    check("rst memWrMask", 32'(memWrMask), 32'd0);
    check("rst fp ctl", 32'({fp_m1Ack, fp_m0Ack, fp_m1Err, fp_m0Err, fp_memWr, fp_memWrMask}), 32'd0);
    check("rst fp addr", fp_memAddr, 32'd0);
    check("rst fp wdata", fp_memWriteData, 32'd0);
    check("rst fp rd", fp_m0RdData | fp_m1RdData, 32'd0);

    mem_init = 1'b0;
    reset = 1'b0;

    // Single write then read back by the other master
    xfer("A m0 wr", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0);
    xfer("B m1 rd", 1'b1, 1'b0, 32'h10, 32'h0,       4'h0, 1'b0, 1'b0, 32'hDEADBEEF);

    // Both held high: alternate M0, M1, ... one ack every two cycles (last grant was M1)
    m0Req = 1'b1; m0Wr = 1'b0; m0Addr = 32'h10; m0WrMask = 4'h0;
    m1Req = 1'b1; m1Wr = 1'b0; m1Addr = 32'h14; m1WrMask = 4'h0;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("C%0d m0Ack", i), 32'(m0Ack), 32'((i % 4) == 2));
      check($sformatf("C%0d m1Ack", i), 32'(m1Ack), 32'((i % 4) == 0));
      check($sformatf("C%0d fp acks", i), 32'({fp_m1Ack, fp_m0Ack}), 32'({m1Ack, m0Ack}));
      if ((i % 4) == 2) check($sformatf("C%0d m0RdData", i), m0RdData, 32'hDEADBEEF);
    end
    m0Req = 1'b0; m1Req = 1'b0;
    step();

    // Grant M0 alone so round-robin now favours M1 while fixed priority still picks M0
    xfer("D m0 rd", 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, 32'hDEADBEEF);
    m0Req = 1'b1; m0Wr = 1'b0; m0Addr = 32'h10;
    m1Req = 1'b1; m1Wr = 1'b0; m1Addr = 32'h14;
    step();
    check("D rr memAddr", memAddr, 32'h14);
    check("D fp memAddr", fp_memAddr, 32'h10);
    m0Req = 1'b0; m1Req = 1'b0;
    step();
    check("D rr acks", 32'({m1Ack, m0Ack}), 32'b10);
    check("D fp acks", 32'({fp_m1Ack, fp_m0Ack}), 32'b01);
    step();

    // Range boundary: word WORDS-1 is the last valid one, byte address WORDS*4 is out of range
    xfer("E0 wr w0",    1'b0, 1'b1, 32'h0,        32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 32'h0);
    xfer("E1 oor wr",   1'b1, 1'b1, 32'h40,       32'h12345678, 4'hF, 1'b0, 1'b1, 32'h0);
    xfer("E2 top wr",   1'b0, 1'b1, 32'h3C,       32'hAABBCCDD, 4'h5, 1'b1, 1'b0, 32'h0);
    xfer("E3 oor rd",   1'b0, 1'b0, 32'h40,       32'h0,        4'h0, 1'b0, 1'b1, 32'h0);
    xfer("E4 rd w0",    1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 1'b0, 32'hCAFEF00D);
    xfer("E5 rd w15",   1'b1, 1'b0, 32'h3C,       32'h0,        4'h0, 1'b0, 1'b0, 32'h00BB00DD);
    xfer("E6 oor high", 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 1'b0, 1'b1, 32'h0);

    // Reset mid-ISSUE of a write: memWr falls without a clock edge and no ack follows
    m0Req = 1'b1; m0Wr = 1'b1; m0Addr = 32'h8; m0WrData = 32'h55555555; m0WrMask = 4'hF;
    step();
    check("F memWr before rst", 32'(memWr), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("F memWr async", 32'(memWr), 32'd0);
    check("F memAddr async", memAddr, 32'd0);
    check("F fp memWr async", 32'(fp_memWr), 32'd0);
    m0Req = 1'b0;
    step();
    check("F no ack 1", 32'({m1Ack, m0Ack}), 32'd0);
    step();
    check("F no ack 2", 32'({m1Ack, m0Ack}), 32'd0);
    reset = 1'b0;

    // First edge after release: tie goes to M0, normal latency, dropped write never reached RAM
    m0Req = 1'b1; m0Wr = 1'b0; m0Addr = 32'h0;
    m1Req = 1'b1; m1Wr = 1'b0; m1Addr = 32'h8;
    step();
    check("G memAddr m0", memAddr, 32'h0);
    check("G fp memAddr m0", fp_memAddr, 32'h0);
    m0Req = 1'b0;
    step();
    check("G m0Ack", 32'({m1Ack, m0Ack}), 32'b01);
    check("G m0RdData", m0RdData, 32'hCAFEF00D);
    step();
    check("G memAddr m1", memAddr, 32'h8);
    m1Req = 1'b0;
    step();
    check("G m1Ack", 32'({m1Ack, m0Ack}), 32'b10);
    check("G m1RdData w2", m1RdData, 32'h0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 Parameter WORD_CNT, default 1024: number of 32-bit words behind the shared RAM data port.
REQ-002 Parameter FIXED_PRIO, default 0: 0 selects round-robin arbitration; 1 makes M0 always win.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 m0Req, m1Req  input  1 each  requester access request, held high until that requester's ack.
REQ-006 m0Wr, m1Wr  input  1 each  1 = write, 0 = read.
REQ-007 m0Addr, m1Addr  input  32 each  byte address; bits [1:0] are ignored.
REQ-008 m0WrData, m1WrData  input  32 each  write data.
REQ-009 m0WrMask, m1WrMask  input  4 each  byte write enables.
REQ-010 m0Ack, m1Ack  output  1 each  one-cycle transfer completion pulse.
REQ-011 m0Err, m1Err  output  1 each  out-of-range flag, valid only while the matching ack is high.
REQ-012 m0RdData, m1RdData  output  32 each  read data, valid only while the matching ack is high.
REQ-013 memAddr  output  32  RAM port address.
REQ-014 memWriteData  output  32  RAM port write data.
REQ-015 memWrMask  output  4  RAM port byte mask.
REQ-016 memWr  output  1  RAM port write enable.
REQ-017 memReadData  input  32  RAM port read data, synchronous, valid one cycle after memAddr.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE and RESP.
REQ-019 IDLE: if any request is high at the clock edge, the arbiter SHALL latch the winner's id, wr, addr, wrData and mask, then enter ISSUE; otherwise it stays in IDLE.
REQ-020 ISSUE: memAddr, memWriteData and memWrMask SHALL be driven from the latched registers; memWr = latched wr AND in-range; next state RESP.
REQ-021 RESP: the owner's ack SHALL be high for exactly one cycle, with rdData = memReadData for an in-range read, else 0.
REQ-022 In RESP, arbitration SHALL consider only the non-owner's request (the owner's req is still high); if that request is high, latch it and go to ISSUE, else go to IDLE.
REQ-023 Latency SHALL be fixed: req sampled at edge N gives memory access in cycle N+1 and ack in cycle N+2, for reads and writes alike.
REQ-024 Sustained alternating traffic SHALL reach one transfer per two cycles.
REQ-025 Round-robin (FIXED_PRIO=0): with both requests high, the winner SHALL be the master not granted most recently; the pointer updates on each latch.
REQ-026 After reset, the round-robin priority SHALL favour M0.
REQ-027 Range check: addr[31:2] >= WORD_CNT SHALL make the access out of range; for such an access memWr stays 0, rdData = 0 and err = 1 together with ack.
REQ-028 Outside ISSUE, memWr SHALL be 0 and memAddr, memWriteData and memWrMask SHALL be 0.
REQ-029 The non-owner's ack, err and rdData SHALL be 0 at all times.
REQ-030 A requester dropping req before its ack SHALL NOT cancel the latched transfer; the ack is still issued.
REQ-031 Latched fields SHALL NOT change between latch and ack, even if the requester's inputs change.

Reset
REQ-032 On reset assertion, the FSM SHALL go to IDLE immediately without waiting for a clock edge.
REQ-033 During reset, every output SHALL be 0; memWr SHALL fall with no clock edge.
REQ-034 Any transfer in flight when reset asserts SHALL be dropped with no ack.
REQ-035 Latched registers SHALL clear to 0 on reset.
REQ-036 The first request after reset deassertion SHALL be sampled at the first rising edge with reset low.

Verification
REQ-037 M0 single write: addr 0x10, data 0xDEADBEEF, mask 0xF -> memWr=1 in cycle N+1 with memAddr 0x10; m0Ack in cycle N+2 with m0Err=0.
REQ-038 M1 read back of 0x10 after REQ-037 -> m1Ack in cycle N+2 with m1RdData=0xDEADBEEF; m0Ack stays 0.
REQ-039 Both requests held high for 8 transfers, FIXED_PRIO=0 -> grant order M0,M1,M0,M1,...; one ack every 2 cycles; no requester acked twice in a row.
REQ-040 Same stimulus with FIXED_PRIO=1 and M0 re-requesting the cycle after each ack -> M0 wins every arbitration in which both requests are present.
REQ-041 Write to addr WORD_CNT*4, mask 0xF -> memWr never asserts; ack with err=1 and rdData=0; a later read of word 0 returns its previous value.
REQ-042 Reset asserted mid-cycle during ISSUE of a write -> memWr drops at once; no ack; the next request after release completes normally with the REQ-023 latency.
